// File: rtl/conv_mac_stream.sv
// conv_mac_stream
//   Takes one coefficient from the weight stream and one activation from the
//   input-feature stream together, and accumulates KERN_SIZE signed products.
//   Each finished dot product is shifted right by FRAC_BITS (floor), optionally
//   clamped at zero (ReLU), saturated to DATA_W bits and written to the output
//   FIFO. All three interfaces use the ap_fifo handshake.
//
// Ports
//   ap_clk            clock, rising edge
//   ap_rst            asynchronous reset, active high
//   weight_V_dout     coefficient at the head of the weight FIFO (signed)
//   weight_V_empty_n  weight FIFO holds data
//   weight_V_read     pop weight FIFO (always together with act_V_read)
//   act_V_dout        activation at the head of the activation FIFO (signed)
//   act_V_empty_n     activation FIFO holds data
//   act_V_read        pop activation FIFO (always together with weight_V_read)
//   out_V_din         registered result word
//   out_V_full_n      output FIFO has space
//   out_V_write       push out_V_din
module conv_mac_stream #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEFF_W   = 16,
  parameter int unsigned KERN_SIZE = 9,
  parameter int unsigned ACC_W     = 40,
  parameter int unsigned FRAC_BITS = 8,
  parameter bit          RELU      = 1'b1
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic [COEFF_W-1:0] weight_V_dout,
  input  logic               weight_V_empty_n,
  output logic               weight_V_read,
  input  logic [DATA_W-1:0]  act_V_dout,
  input  logic               act_V_empty_n,
  output logic               act_V_read,
  output logic [DATA_W-1:0]  out_V_din,
  input  logic               out_V_full_n,
  output logic               out_V_write
);

  localparam int unsigned PROD_W = DATA_W + COEFF_W;
  localparam int unsigned CNT_W  = (KERN_SIZE > 1) ? $clog2(KERN_SIZE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KERN_SIZE - 1);

  // Saturation bounds expressed at accumulator width for the compare,
  // and at output width for the clamped value.
  localparam logic signed [ACC_W-1:0] SAT_MAX_A =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN_A =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] SAT_MAX_D = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN_D = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ACC,
    SCALE,
    OUT
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]         result_q, result_d;
  logic                      run_q;

  logic                      fire;
  logic signed [PROD_W-1:0]  w_ext, a_ext, prod;
  logic signed [ACC_W-1:0]   scaled;
  logic [DATA_W-1:0]         sat_val;

  // run_q keeps every handshake output low while reset is held and for the
  // first cycle after release, independent of the input FIFO flags.
  assign fire          = run_q && (state_q == ACC) && weight_V_empty_n && act_V_empty_n;
  assign weight_V_read = fire;
  assign act_V_read    = fire;
  assign out_V_write   = run_q && (state_q == OUT) && out_V_full_n;
  assign out_V_din     = result_q;

  // Both operands are sign-extended to the full product width so the
  // multiply is exact in two's complement.
  assign w_ext = PROD_W'($signed(weight_V_dout));
  assign a_ext = PROD_W'($signed(act_V_dout));
  assign prod  = w_ext * a_ext;

  assign scaled = acc_q >>> FRAC_BITS;

  always_comb begin
    sat_val = scaled[DATA_W-1:0];
    if (RELU && (scaled < 0)) begin
      sat_val = '0;
    end else if (scaled > SAT_MAX_A) begin
      sat_val = SAT_MAX_D;
    end else if (scaled < SAT_MIN_A) begin
      sat_val = SAT_MIN_D;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    result_d = result_q;
    unique case (state_q)
      ACC: begin
        if (fire) begin
          acc_d = acc_q + ACC_W'(prod);
          if (count_q == CNT_LAST) begin
            count_d = '0;
            state_d = SCALE;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      SCALE: begin
        result_d = sat_val;
        acc_d    = '0;
        state_d  = OUT;
      end
      OUT: begin
        if (out_V_write) begin
          state_d = ACC;
        end
      end
      default: begin
        state_d = ACC;
      end
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q  <= ACC;
      count_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      run_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_mac_stream.sv
`timescale 1ns/1ps
module tb_conv_mac_stream;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int K  = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] w_dout;
  logic          w_en;
  logic [DW-1:0] a_dout;
  logic          a_en;
  logic          full_n;
  logic          rd_w1, rd_a1, wr1, rd_w0, rd_a0, wr0;
  logic [DW-1:0] din1, din0;

  always #5 clk = ~clk;

  conv_mac_stream #(
    .DATA_W(DW), .COEFF_W(CW), .KERN_SIZE(K), .ACC_W(40), .FRAC_BITS(8), .RELU(1'b1)
  ) dut_relu (
    .ap_clk(clk), .ap_rst(rst),
    .weight_V_dout(w_dout), .weight_V_empty_n(w_en), .weight_V_read(rd_w1),
    .act_V_dout(a_dout), .act_V_empty_n(a_en), .act_V_read(rd_a1),
    .out_V_din(din1), .out_V_full_n(full_n), .out_V_write(wr1)
  );

  conv_mac_stream #(
    .DATA_W(DW), .COEFF_W(CW), .KERN_SIZE(K), .ACC_W(40), .FRAC_BITS(8), .RELU(1'b0)
  ) dut_lin (
    .ap_clk(clk), .ap_rst(rst),
    .weight_V_dout(w_dout), .weight_V_empty_n(w_en), .weight_V_read(rd_w0),
    .act_V_dout(a_dout), .act_V_empty_n(a_en), .act_V_read(rd_a0),
    .out_V_din(din0), .out_V_full_n(full_n), .out_V_write(wr0)
  );

  typedef struct {
    logic [DW-1:0] r1;
    logic [DW-1:0] r0;
  } exp_t;

  logic [CW-1:0] wq[$];
  logic [DW-1:0] aq[$];
  exp_t          sb[$];
  logic [CW-1:0] wv[K];
  logic [DW-1:0] av[K];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_rd  = -100;
  int n_in     = 0;
  bit pending  = 1'b0;
  bit blk      = 1'b1;
  bit w_gate   = 1'b1;
  bit a_gate   = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [CW-1:0] w[K],
                                          input logic [DW-1:0] a[K], input bit relu);
    longint sum = 0;
    longint s;
    for (int i = 0; i < K; i++)
      sum += longint'($signed(w[i])) * longint'($signed(a[i]));
    s = sum >>> 8;
    if (relu && s < 0) s = 0;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return s[DW-1:0];
  endfunction

  task automatic push_frame();
    for (int i = 0; i < K; i++) begin
      wq.push_back(wv[i]);
      aq.push_back(av[i]);
    end
    sb.push_back('{r1: model(wv, av, 1'b1), r0: model(wv, av, 1'b0)});
  endtask

  task automatic set_frame(input logic [CW-1:0] w, input logic [DW-1:0] a);
    for (int i = 0; i < K; i++) begin
      wv[i] = w;
      av[i] = a;
    end
  endtask

  task automatic set_nominal();
    for (int i = 0; i < K; i++) begin
      wv[i] = 16'h0100;
      av[i] = DW'(i + 1);
    end
  endtask

  task automatic drive();
    w_en   = w_gate && (wq.size() > 0);
    a_en   = a_gate && (aq.size() > 0);
    w_dout = '0;
    a_dout = '0;
    if (wq.size() > 0) w_dout = wq[0];
    if (aq.size() > 0) a_dout = aq[0];
  endtask

  // One clock cycle: check at the falling edge, update FIFO model after the rising edge.
  task automatic tick();
    logic exp_rd, exp_wr, stall, rw, ra;
    @(negedge clk);
    exp_rd = !blk && w_en && a_en && !pending;
    exp_wr = !blk && pending && (cyc >= last_rd + 2) && full_n;
    stall  = !blk && pending && (cyc >= last_rd + 2) && !full_n;
    chk("reads", {rd_w1, rd_a1, rd_w0, rd_a0}, {4{exp_rd}});
    chk("write", {wr1, wr0}, {2{exp_wr}});
    if (blk) chk("din_reset", {din1, din0}, 32'd0);
    if ((exp_wr || stall) && sb.size() > 0) begin
      chk(stall ? "din_hold_relu" : "din_relu", din1, sb[0].r1);
      chk(stall ? "din_hold_lin" : "din_lin", din0, sb[0].r0);
    end
    if (exp_rd) begin
      last_rd = cyc;
      n_in++;
      if (n_in == K) begin
        pending = 1'b1;
        n_in    = 0;
      end
    end
    if (exp_wr) begin
      pending = 1'b0;
      if (sb.size() > 0) void'(sb.pop_front());
    end
    rw = rd_w1;
    ra = rd_a1;
    @(posedge clk);
    #1;
    cyc++;
    if (rw && wq.size() > 0) void'(wq.pop_front());
    if (ra && aq.size() > 0) void'(aq.pop_front());
    drive();
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    while ((sb.size() > 0 || pending) && n < max) begin
      tick();
      n++;
    end
    if (n >= max) chk("timeout_pending_results", sb.size(), 0);
    tick();
    tick();
  endtask

  task automatic reset_begin();
    rst = 1'b1;
    blk = 1'b1;
    wq.delete();
    aq.delete();
    sb.delete();
    pending = 1'b0;
    n_in    = 0;
    last_rd = -100;
    drive();
  endtask

  task automatic reset_end(input int n);
    repeat (n) tick();
    rst = 1'b0;
    tick();
    blk = 1'b0;
  endtask

  initial begin : stim
    int guard;
    full_n = 1'b1;
    reset_begin();

    // Nominal: three back-to-back frames, period KERN_SIZE+2.
    set_nominal();
    push_frame();
    push_frame();
    push_frame();
    reset_end(3);
    run_idle(80);

    // Saturation, positive and negative.
    set_frame(16'h7FFF, 16'h7FFF);
    push_frame();
    set_frame(16'h7FFF, 16'h8000);
    push_frame();
    run_idle(60);

    // ReLU on a small negative result, and floor rounding of acc=-1.
    set_frame(16'h0100, 16'hFFFF);
    push_frame();
    set_frame(16'h0000, 16'h0000);
    wv[0] = 16'h0001;
    av[0] = 16'hFFFF;
    push_frame();
    run_idle(60);

    // Input stalls: weight flag toggles, activation flag drops for 4 cycles.
    set_nominal();
    push_frame();
    for (int i = 0; i < 60 && sb.size() > 0; i++) begin
      w_gate = (i % 2) == 0;
      a_gate = !(i >= 5 && i < 9);
      drive();
      tick();
    end
    w_gate = 1'b1;
    a_gate = 1'b1;
    drive();
    run_idle(40);

    // Backpressure: full_n low for 5 cycles of OUT, next frame waiting.
    push_frame();
    push_frame();
    full_n = 1'b0;
    guard  = 0;
    while (!pending && guard < 40) begin
      tick();
      guard++;
    end
    if (guard >= 40) chk("timeout_frame_fill", n_in, K);
    tick();
    repeat (5) tick();
    full_n = 1'b1;
    run_idle(60);

    // Reset after 4 pairs; the fresh frame must produce a clean result.
    push_frame();
    guard = 0;
    while (n_in < 4 && guard < 40) begin
      tick();
      guard++;
    end
    if (guard >= 40) chk("timeout_partial", n_in, 4);
    reset_begin();
    push_frame();
    reset_end(3);
    run_idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_mac_stream.md
Name: conv_mac_stream

Overview:
- Downstream consumer of a layer's weight streamer. Pairs each coefficient with one activation from the input-feature stream and accumulates KERN_SIZE signed products.
- Rescales each completed dot product by FRAC_BITS, applies optional ReLU, saturates to DATA_W and pushes the result into the next layer's FIFO.
- All three interfaces use the codebase's ap_fifo handshake (dout/empty_n/read on inputs, din/full_n/write on the output).

Parameters:
- DATA_W, 16, activation and output width (signed two's complement).
- COEFF_W, 16, weight width (signed). Same value as the codebase coeff_width.
- KERN_SIZE, 9, products per output. Must be ≥1; equals the layer's kern_s value.
- ACC_W, 40, accumulator width (signed). Must be ≥ DATA_W+COEFF_W+clog2(KERN_SIZE).
- FRAC_BITS, 8, arithmetic right shift applied to the accumulator before saturation.
- RELU, 1, when 1, negative results are clamped to 0 before saturation.

Ports:
- ap_clk  in  1  clock. All logic is rising-edge.
- ap_rst  in  1  asynchronous, active-high reset.
- weight_V_dout  in  COEFF_W  coefficient at the head of the weight FIFO.
- weight_V_empty_n  in  1  weight FIFO non-empty.
- weight_V_read  out  1  pops the weight FIFO.
- act_V_dout  in  DATA_W  activation at the head of the activation FIFO.
- act_V_empty_n  in  1  activation FIFO non-empty.
- act_V_read  out  1  pops the activation FIFO.
- out_V_din  out  DATA_W  result word.
- out_V_full_n  in  1  output FIFO has space.
- out_V_write  out  1  pushes out_V_din.

Behaviour:
- Reset (asynchronous, any time): state=ACC, count=0, acc=0, result register=0. All outputs are 0 while ap_rst is high and in the first cycle after release. A partial dot product is discarded and not resumed.
- FSM states: ACC, SCALE, OUT.
- ACC:
  - fire = weight_V_empty_n & act_V_empty_n.
  - weight_V_read = act_V_read = fire. Both FIFOs are always popped together; a single-sided read is illegal.
  - On fire: acc <= acc + sext(weight)*sext(act), full-precision signed product, and count <= count+1.
  - When fire occurs with count==KERN_SIZE-1: count <= 0 and go to SCALE.
  - No fire: everything holds.
- SCALE (exactly one cycle, no reads):
  - s = acc >>> FRAC_BITS (arithmetic shift, floor rounding).
  - If RELU and s<0, then s=0.
  - Saturate s to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and register it into the result register.
  - acc <= 0. Go to OUT.
- OUT:
  - out_V_din = result register. The register drives the port continuously and is stable for the whole state.
  - out_V_write = out_V_full_n. It is never asserted while full_n is low.
  - When a write occurs, go to ACC. No reads happen in OUT.
- Latency: the write occurs at the earliest 2 cycles after the cycle that pops the last pair (SCALE, then OUT), and 1 cycle later per cycle of full_n low.
- Throughput: KERN_SIZE+2 cycles per output with no stalls.
- Stalls: either input empty stalls accumulation with no data loss. Output backpressure blocks further reads, so no input is consumed while a result is pending.
- Simultaneous events: a valid pair arriving in SCALE or OUT is not read. It is consumed in the first ACC cycle.
- KERN_SIZE=1: every fire goes straight to SCALE.
- Overflow: with a correctly sized ACC_W the accumulator cannot wrap. No internal overflow detection is required.
- out_V_din is registered. weight_V_read, act_V_read and out_V_write are combinational from state and the handshake inputs only (no data-dependent paths).

Test Plan:
- Nominal (KERN_SIZE=9, FRAC_BITS=8, RELU=1): weights all 0x0100, activations 1..9, FIFOs always non-empty, full_n=1 -> exactly 9 joint reads on consecutive cycles, one write with out_V_din=45 two cycles after the 9th read. Repeat 3 frames -> 3 writes of 45, period 11 cycles.
- Saturation: weights 0x7FFF, activations 0x7FFF -> out_V_din=0x7FFF. Weights 0x7FFF, activations 0x8000 with RELU=0 -> out_V_din=0x8000.
- ReLU/rounding: weights 0x0100, activations all -1 -> RELU=1 gives 0; RELU=0 gives 0xFFF7 (-9). Single product of -1*1 with FRAC_BITS=8 (acc=-1) gives -1 (floor, not 0).
- Input stalls: weight_V_empty_n toggles every cycle, and act_V_empty_n is low for 4 cycles mid-frame -> reads only on cycles where both are high, never single-sided; result identical to the nominal case.
- Backpressure: out_V_full_n held low for 5 cycles on entering OUT -> out_V_write=0, no reads, out_V_din stable. Write happens in the cycle full_n rises, and reads resume the following cycle.
- Reset mid-frame: assert ap_rst after 4 pairs consumed, release, then send 9 fresh pairs of the nominal data -> all outputs 0 during reset, and the next result is 45, with no contribution from the first 4 pairs.
